// File: rtl/vector_stream_pkg.sv
// vector_stream_pkg: FSM state encoding and index-width helper shared by vector_stream_tx.
package vector_stream_pkg;
    typedef enum logic {ST_IDLE, ST_SEND} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vec_hold_reg.sv
// vec_hold_reg: single-entry window buffer with full flag; load captures din, unload frees the entry.
module vec_hold_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            full <= 1'b0;
        end else begin
            if (load) dout <= din;
            full <= load | (full & ~unload);
        end
    end
endmodule

// File: rtl/vector_stream_tx.sv
// vector_stream_tx: accepts an N-element window in parallel and emits it serially with en/eop.
// Define VECTOR_STREAM_TX_SKID_EN to add a holding register for zero-bubble back-to-back windows.
module vector_stream_tx
    import vector_stream_pkg::*;
#(
    parameter int N     = 4,
    parameter int DIN_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic [N*DIN_W-1:0] vec_data,
    output logic               op_dout_en,
    output logic               op_dout_eop,
    output logic [DIN_W-1:0]   op_dout,
    output logic               res_vld
);
    localparam int IW = idx_w(N);
    localparam int VW = N * DIN_W;

    state_t        state;
    logic [IW-1:0] idx;
    logic [VW-1:0] shreg, hold_data, next_data;
    logic          hold_full, xfer, last, avail;

    assign xfer      = vec_valid && vec_ready;
    assign last      = idx == IW'(N - 1);
    assign avail     = hold_full || xfer;
    assign next_data = hold_full ? hold_data : vec_data;

`ifdef VECTOR_STREAM_TX_SKID_EN
    assign vec_ready = !rst && !hold_full;
    // Transfers during a window park in the hold register; at the last element they go straight in.
    vec_hold_reg #(.W(VW)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (xfer && state == ST_SEND && !last),
        .unload (state == ST_SEND && last && hold_full),
        .din    (vec_data),
        .dout   (hold_data),
        .full   (hold_full)
    );
`else
    assign vec_ready = !rst && state == ST_IDLE;
    assign hold_full = 1'b0;
    assign hold_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            shreg       <= '0;
            op_dout_en  <= 1'b0;
            op_dout_eop <= 1'b0;
            op_dout     <= '0;
            res_vld     <= 1'b0;
        end else begin
            res_vld     <= op_dout_eop;
            op_dout_en  <= state == ST_SEND;
            op_dout_eop <= state == ST_SEND && last;
            op_dout     <= state == ST_SEND ? shreg[DIN_W-1:0] : '0;
            if (state == ST_IDLE) begin
                idx <= '0;
                if (xfer) begin
                    shreg <= vec_data;
                    state <= ST_SEND;
                end
            end else begin
                idx   <= last ? '0 : idx + IW'(1);
                shreg <= (last && avail) ? next_data : shreg >> DIN_W;
                if (last && !avail) state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_vector_stream_tx.sv
// tb_vector_stream_tx: directed and randomized checks of vector_stream_tx (N=4, N=1, N=5 instances)
// against expectations built from window contents and a queue scoreboard.
module tb_vector_stream_tx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

`ifdef VECTOR_STREAM_TX_SKID_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 1;
`endif

    logic v4, r4, e4, p4, rv4;
    logic [63:0] d4;
    logic [15:0] o4;
    logic v1, r1, e1, p1, rv1;
    logic [15:0] d1, o1;
    logic v5, r5, e5, p5, rv5;
    logic [79:0] d5;
    logic [15:0] o5;

    vector_stream_tx #(.N(4), .DIN_W(16)) u4 (
        .clk(clk), .rst(rst), .vec_valid(v4), .vec_ready(r4), .vec_data(d4),
        .op_dout_en(e4), .op_dout_eop(p4), .op_dout(o4), .res_vld(rv4));
    vector_stream_tx #(.N(1), .DIN_W(16)) u1 (
        .clk(clk), .rst(rst), .vec_valid(v1), .vec_ready(r1), .vec_data(d1),
        .op_dout_en(e1), .op_dout_eop(p1), .op_dout(o1), .res_vld(rv1));
    vector_stream_tx #(.N(5), .DIN_W(16)) u5 (
        .clk(clk), .rst(rst), .vec_valid(v5), .vec_ready(r5), .vec_data(d5),
        .op_dout_en(e5), .op_dout_eop(p5), .op_dout(o5), .res_vld(rv5));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        v4 = 1'b0; v1 = 1'b0; v5 = 1'b0;
        d4 = '0; d1 = '0; d5 = '0;
        repeat (2) tick;
        checks++;
        if ({r4, r1, r5} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready: got %b%b%b want 000", r4, r1, r5);
        end
        checks++;
        if ({e4, p4, o4, rv4, e1, p1, o1, rv1, e5, p5, o5, rv5} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: u4 %b%b%h%b u1 %b%b%h%b u5 %b%b%h%b want all 0",
                     e4, p4, o4, rv4, e1, p1, o1, rv1, e5, p5, o5, rv5);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({r4, r1, r5} !== 3'b111) begin
            failures++;
            $display("FAIL reset_release_ready: got %b%b%b want 111", r4, r1, r5);
        end
    endtask

    task automatic test_single(input logic [63:0] w, input string name);
        int mx, omax;
        logic signed [15:0] el;
        logic [15:0] xd;
        mx = -32768;
        omax = -32768;
        for (int k = 0; k < 4; k++) begin
            el = w[k*16 +: 16];
            if (el > mx) mx = el;
        end
        checks++;
        if (r4 !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready: got %b want 1", name, r4);
        end
        d4 = w;
        v4 = 1'b1;
        tick;
        v4 = 1'b0;
        d4 = {$urandom, $urandom};
        for (int c = 1; c <= 6; c++) begin
            tick;
            xd = (c <= 4) ? w[(c-1)*16 +: 16] : 16'h0;
            checks++;
            if ({e4, p4, o4, rv4} !== {c <= 4, c == 4, xd, c == 5}) begin
                failures++;
                $display("FAIL %s_cycle%0d: got en=%b eop=%b dout=%0d res=%b want en=%b eop=%b dout=%0d res=%b",
                         name, c, e4, p4, $signed(o4), rv4, c <= 4, c == 4, $signed(xd), c == 5);
            end
            if (e4 && $signed(o4) > omax) omax = $signed(o4);
        end
        checks++;
        if (omax != mx) begin
            failures++;
            $display("FAIL %s_max: got %0d want %0d", name, omax, mx);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] wa, wb;
        logic xf, started;
        int acc, mx;
        logic en_q[$], eop_q[$], xen_q[$], xeop_q[$];
        logic [15:0] dat_q[$], xdat_q[$];
        int maxq[$];
        wa = {16'd4, 16'd3, 16'd2, 16'd1};
        wb = {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF};
        acc = 0;
        started = 1'b0;
        d4 = wa;
        v4 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            xf = v4 && r4;
            tick;
            if (xf) begin
                acc++;
                if (acc == 1) d4 = wb;
                else v4 = 1'b0;
            end
            if (started || e4) begin
                started = 1'b1;
                en_q.push_back(e4);
                eop_q.push_back(p4);
                dat_q.push_back(o4);
            end
        end
        for (int k = 0; k < 4; k++) begin
            xen_q.push_back(1'b1); xeop_q.push_back(k == 3); xdat_q.push_back(wa[k*16 +: 16]);
        end
        for (int g = 0; g < GAP; g++) begin
            xen_q.push_back(1'b0); xeop_q.push_back(1'b0); xdat_q.push_back(16'h0);
        end
        for (int k = 0; k < 4; k++) begin
            xen_q.push_back(1'b1); xeop_q.push_back(k == 3); xdat_q.push_back(wb[k*16 +: 16]);
        end
        checks++;
        if (acc != 2) begin
            failures++;
            $display("FAIL b2b_accepts: got %0d want 2", acc);
        end
        for (int i = 0; i < xen_q.size(); i++) begin
            checks++;
            if (i >= en_q.size()) begin
                failures++;
                $display("FAIL b2b_slot%0d: got nothing want en=%b dout=%0d", i, xen_q[i], $signed(xdat_q[i]));
            end else if ({en_q[i], eop_q[i], dat_q[i]} !== {xen_q[i], xeop_q[i], xdat_q[i]}) begin
                failures++;
                $display("FAIL b2b_slot%0d: got en=%b eop=%b dout=%0d want en=%b eop=%b dout=%0d",
                         i, en_q[i], eop_q[i], $signed(dat_q[i]), xen_q[i], xeop_q[i], $signed(xdat_q[i]));
            end
        end
        mx = -32768;
        for (int i = 0; i < en_q.size(); i++) begin
            if (en_q[i]) begin
                if ($signed(dat_q[i]) > mx) mx = $signed(dat_q[i]);
                if (eop_q[i]) begin
                    maxq.push_back(mx);
                    mx = -32768;
                end
            end
        end
        checks++;
        if (maxq.size() != 2 || maxq[0] != 4 || maxq[1] != -1) begin
            failures++;
            $display("FAIL b2b_max: got %0d windows first=%0d second=%0d want 2 windows 4 and -1",
                     maxq.size(), maxq.size() > 0 ? maxq[0] : 0, maxq.size() > 1 ? maxq[1] : 0);
        end
    endtask

    task automatic test_n1;
        logic [15:0] w[3];
        logic xf, prev_p;
        int acc, ne, nr;
        w[0] = 16'd9; w[1] = 16'hFFF7; w[2] = 16'd0;
        acc = 0; ne = 0; nr = 0;
        prev_p = p1;
        d1 = w[0];
        v1 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            xf = v1 && r1;
            tick;
            if (xf) begin
                acc++;
                if (acc < 3) d1 = w[acc];
                else v1 = 1'b0;
            end
            checks++;
            if (rv1 !== prev_p) begin
                failures++;
                $display("FAIL n1_res_vld cycle%0d: got %b want %b", c, rv1, prev_p);
            end
            checks++;
            if (e1) begin
                if (ne >= 3 || p1 !== 1'b1 || o1 !== w[ne]) begin
                    failures++;
                    $display("FAIL n1_elem%0d: got eop=%b dout=%0d want eop=1 dout=%0d",
                             ne, p1, $signed(o1), ne < 3 ? $signed(w[ne]) : 0);
                end
                ne++;
            end else if (p1 !== 1'b0 || o1 !== 16'h0) begin
                failures++;
                $display("FAIL n1_idle cycle%0d: got eop=%b dout=%h want 0 0", c, p1, o1);
            end
            if (rv1) nr++;
            prev_p = p1;
        end
        checks++;
        if (ne != 3 || nr != 3) begin
            failures++;
            $display("FAIL n1_counts: got elems=%0d res=%0d want 3 3", ne, nr);
        end
    endtask

    task automatic test_reset_mid;
        d4 = {16'd2, 16'd4, 16'd6, 16'd8};
        v4 = 1'b1;
        tick;
        v4 = 1'b0;
        repeat (2) tick;
        checks++;
        if (e4 !== 1'b1 || o4 !== 16'd6) begin
            failures++;
            $display("FAIL rstmid_elem1: got en=%b dout=%0d want en=1 dout=6", e4, $signed(o4));
        end
        rst = 1'b1;
        tick;
        checks++;
        if ({r4, e4, p4, o4, rv4} !== '0) begin
            failures++;
            $display("FAIL rstmid_reset: got ready=%b en=%b eop=%b dout=%h res=%b want all 0", r4, e4, p4, o4, rv4);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            checks++;
            if ({e4, p4, rv4} !== 3'b000) begin
                failures++;
                $display("FAIL rstmid_quiet cycle%0d: got en=%b eop=%b res=%b want 0 0 0", c, e4, p4, rv4);
            end
        end
        test_single({16'd1, 16'd0, 16'h8000, 16'h7FFF}, "post_rst");
    endtask

    task automatic test_random;
        logic [15:0] exp_q[$];
        logic [15:0] ex;
        logic xf, prev_p;
        int acc, pos, eops, nres, cyc;
        acc = 0; pos = 0; eops = 0; nres = 0; cyc = 0;
        v5 = 1'b0;
        prev_p = p5;
        while ((acc < 1000 || exp_q.size() != 0 || prev_p) && cyc < 30000) begin
            if (v5) begin
                if ($urandom_range(7, 0) == 0) v5 = 1'b0;
                else if ($urandom_range(3, 0) == 0) d5 = {16'($urandom), $urandom, $urandom};
            end else if (acc < 1000 && $urandom_range(1, 0) == 1) begin
                v5 = 1'b1;
                d5 = {16'($urandom), $urandom, $urandom};
            end
            xf = v5 && r5;
            tick;
            if (xf) begin
                for (int k = 0; k < 5; k++) exp_q.push_back(d5[k*16 +: 16]);
                acc++;
                v5 = 1'b0;
            end
            checks++;
            if (rv5 !== prev_p) begin
                failures++;
                $display("FAIL rand_res_vld cycle%0d: got %b want %b", cyc, rv5, prev_p);
            end
            if (rv5) nres++;
            checks++;
            if (e5) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected cycle%0d: got dout=%h want no element", cyc, o5);
                end else begin
                    ex = exp_q.pop_front();
                    if (o5 !== ex || p5 !== (pos == 4)) begin
                        failures++;
                        $display("FAIL rand_elem cycle%0d pos%0d: got dout=%h eop=%b want dout=%h eop=%b",
                                 cyc, pos, o5, p5, ex, pos == 4);
                    end
                end
                pos = (pos == 4) ? 0 : pos + 1;
                if (p5) eops++;
            end else if (pos != 0 || p5 !== 1'b0 || o5 !== 16'h0) begin
                failures++;
                $display("FAIL rand_idle cycle%0d: got eop=%b dout=%h at pos%0d want gap-free window and zeros",
                         cyc, p5, o5, pos);
            end
            prev_p = p5;
            cyc++;
        end
        checks++;
        if (cyc >= 30000) begin
            failures++;
            $display("FAIL rand_timeout: got %0d cycles want under 30000", cyc);
        end
        checks++;
        if (acc != 1000 || eops != 1000 || nres != 1000) begin
            failures++;
            $display("FAIL rand_counts: got windows=%0d eops=%0d res=%0d want 1000 each", acc, eops, nres);
        end
    endtask

    initial begin
        test_reset;
        test_single({16'd5, 16'd12, 16'hFFF9, 16'd3}, "single");
        test_back_to_back;
        test_n1;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
